stream_upsizer: RTL

STREAM_UPSIZER -- requirements
Module: stream_upsizer

---
 rtl/stream_upsizer.sv | 93 +++++++++
 1 files changed

// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: gathers `ratio` input beats of `in_width` bits
// into one little-endian output word, flushing early on in_last.
module stream_upsizer #(
    parameter int in_width = 8,
    parameter int ratio    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [in_width-1:0]          in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [in_width*ratio-1:0]    out_data,
    output logic [ratio-1:0]             out_keep,
    output logic                         out_last
);

    localparam int cnt_w = (ratio > 1) ? $clog2(ratio) : 1;
    localparam int acc_w = in_width * (ratio - 1);
    localparam int out_w = in_width * ratio;
    localparam logic [cnt_w-1:0] top_lane = cnt_w'(ratio - 1);

    logic [acc_w-1:0]    acc;
    logic [cnt_w-1:0]    cnt;
    logic                in_fire;
    logic                out_fire;
    logic                complete;
    logic [out_w-1:0]    acc_ext;
    logic [out_w-1:0]    word_data;
    logic [ratio-1:0]    word_keep;

    // Accepting while the output stage is free or draining keeps one beat per cycle.
    assign in_ready = ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign complete = in_fire & ((cnt == top_lane) | in_last);
    assign acc_ext  = {{in_width{1'b0}}, acc};

    // Lanes below cnt come from the accumulator, lane cnt is the current beat,
    // anything higher is forced to zero.
    always_comb begin
        word_data = '0;
        word_keep = '0;
        for (int i = 0; i < ratio; i++) begin
            if (cnt_w'(i) < cnt) begin
                word_data[i*in_width +: in_width] = acc_ext[i*in_width +: in_width];
                word_keep[i] = 1'b1;
            end else if (cnt_w'(i) == cnt) begin
                word_data[i*in_width +: in_width] = in_data;
                word_keep[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_fire) begin
            if (complete) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                for (int i = 0; i < ratio - 1; i++) begin
                    if (cnt == cnt_w'(i)) begin
                        acc[i*in_width +: in_width] <= in_data;
                    end
                end
                cnt <= cnt + cnt_w'(1);
            end
        end
    end

    // A completing beat overrides a same-edge drain so back-to-back words never bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= word_data;
            out_keep  <= word_keep;
            out_last  <= in_last;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule
